// File: rtl/fifo_share_ctrl.sv
// rtl/fifo_share_ctrl.sv - shares one single-port FIFO between two producers and one consumer
module fifo_share_ctrl #(
    parameter int DATA_WIDTH   = 6,
    parameter int MAX_WR_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  rd_req,
    output logic                  rd_valid,
    output logic                  wr_grant_id,
    output logic                  fifo_wr_en,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] fifo_din,
    input  logic                  fifo_full,
    input  logic                  fifo_empty
);

    localparam int BW = $clog2(MAX_WR_BURST + 1);

    logic          rr_ptr;
    logic [BW-1:0] wr_burst;
    logic          wr_pend;
    logic          rd_pend;
    logic          burst_max;
    logic          do_read;
    logic          do_write;
    logic          grant;

    // A read wins only when it is alone or the contended-write streak has hit the limit.
    always_comb begin
        wr_pend   = (req0_valid | req1_valid) & ~fifo_full;
        rd_pend   = rd_req & ~fifo_empty;
        burst_max = (wr_burst == BW'(MAX_WR_BURST));
        do_read   = rd_pend & (~wr_pend | burst_max);
        do_write  = wr_pend & ~do_read;
        grant     = (req0_valid & req1_valid) ? rr_ptr : req1_valid;
    end

    always_comb begin
        fifo_wr_en  = 1'b0;
        fifo_rd_en  = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        wr_grant_id = 1'b0;
        fifo_din    = '0;
        if (!rst) begin
            fifo_rd_en = do_read;
            if (do_write) begin
                fifo_wr_en  = 1'b1;
                wr_grant_id = grant;
                fifo_din    = grant ? req1_data : req0_data;
                req0_ready  = ~grant;
                req1_ready  = grant;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= 1'b0;
            wr_burst <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= do_read;
            if (do_write) begin
                rr_ptr <= ~grant;
            end
            if (do_read || !rd_pend) begin
                wr_burst <= '0;
            end else if (do_write && !burst_max) begin
                wr_burst <= wr_burst + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_share_ctrl.sv
// tb/tb_fifo_share_ctrl.sv - scoreboard bench for fifo_share_ctrl against a cycle reference model
module tb_fifo_share_ctrl;

    localparam int DW  = 6;
    localparam int MAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0;
    logic [DW-1:0] req0_data = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [DW-1:0] req1_data = '0;
    logic          req1_ready;
    logic          rd_req = 1'b0;
    logic          rd_valid;
    logic          wr_grant_id;
    logic          fifo_wr_en;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_din;
    logic          fifo_full = 1'b0;
    logic          fifo_empty = 1'b1;

    fifo_share_ctrl #(.DATA_WIDTH(DW), .MAX_WR_BURST(MAX)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .rd_req(rd_req), .rd_valid(rd_valid), .wr_grant_id(wr_grant_id),
        .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en), .fifo_din(fifo_din),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int wr_en;
        int rd_en;
        int r0;
        int r1;
        int gid;
        int din;
        int rv;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // reference state: preferred producer, contended-write streak, whether a pop was issued last cycle
    int m_pref = 0;
    int m_streak = 0;
    int m_rv = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit v0, input int d0, input bit v1, input int d1,
                         input bit rq, input bit f, input bit e);
        exp_t x;
        int g;
        bit wp, rp, is_rd, is_wr;
        @(negedge clk);
        rst = r; req0_valid = v0; req0_data = DW'(d0); req1_valid = v1; req1_data = DW'(d1);
        rd_req = rq; fifo_full = f; fifo_empty = e;
        #1;
        x = '{0, 0, 0, 0, 0, 0, 0};
        if (r) begin
            m_pref = 0; m_streak = 0; m_rv = 0;
        end else begin
            x.rv  = m_rv;
            wp    = (v0 || v1) && !f;
            rp    = rq && !e;
            is_rd = rp && (!wp || m_streak == MAX);
            is_wr = wp && !is_rd;
            if (is_wr) begin
                g = (v0 && v1) ? m_pref : (v1 ? 1 : 0);
                x.wr_en = 1; x.gid = g; x.din = (g == 1) ? d1 : d0;
                x.r0 = (g == 0); x.r1 = (g == 1);
                m_pref = 1 - g;
            end
            x.rd_en = is_rd;
            if (is_rd || !rp) m_streak = 0;
            else if (is_wr && m_streak < MAX) m_streak = m_streak + 1;
            m_rv = is_rd;
        end
        sb.push_back(x);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wr_en", int'(fifo_wr_en), e.wr_en);
                chk("rd_en", int'(fifo_rd_en), e.rd_en);
                chk("req0_ready", int'(req0_ready), e.r0);
                chk("req1_ready", int'(req1_ready), e.r1);
                chk("grant_id", int'(wr_grant_id), e.gid);
                chk("fifo_din", int'(fifo_din), e.din);
                chk("rd_valid", int'(rd_valid), e.rv);
            end
        end
    end

    initial begin : stim
        drive(1, 1, 5, 1, 42, 1, 0, 0);
        drive(1, 1, 5, 1, 42, 1, 0, 0);

        // round-robin, FIFO never full, no reads
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 'h05, 1, 'h2A, 0, 0, 1);
            chk("rr_grant", int'(wr_grant_id), i % 2);
            chk("rr_din", int'(fifo_din), (i % 2) ? 'h2A : 'h05);
        end

        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 3, 1, 9 + i, 0, 0, 0);
            chk("single_r1_ready", int'(req1_ready), 1);
        end

        // contended: 4 writes then a forced read, repeating
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, i, 1, 20 + i, 1, 0, 0);
            chk("burst_rd_en", int'(fifo_rd_en), (i % 5 == 4) ? 1 : 0);
        end

        drive(0, 1, 1, 1, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 3, 1, 4, 1, 0, 0);
            chk("pre_gap_rd_en", int'(fifo_rd_en), 0);
        end
        drive(0, 1, 5, 1, 6, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 7, 1, 8, 1, 0, 0);
            chk("post_gap_rd_en", int'(fifo_rd_en), (i == 4) ? 1 : 0);
        end

        drive(0, 1, 11, 1, 12, 1, 1, 0);
        chk("full_rd_en", int'(fifo_rd_en), 1);
        chk("full_readies", int'(req0_ready | req1_ready), 0);
        drive(0, 0, 0, 0, 0, 1, 0, 1);
        chk("empty_rd_en", int'(fifo_rd_en), 0);
        drive(0, 0, 0, 0, 0, 1, 0, 1);
        chk("empty_rd_valid", int'(rd_valid), 0);

        // async reset mid-cycle while rd_valid is high
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        @(posedge clk);
        #1;
        chk("pre_rst_rd_valid", int'(rd_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_rd_valid", int'(rd_valid), 0);
        chk("async_rst_enables", int'(fifo_wr_en | fifo_rd_en | req0_ready | req1_ready), 0);
        drive(1, 1, 1, 1, 2, 1, 0, 0);
        drive(0, 1, 'h11, 1, 'h22, 0, 0, 0);
        chk("first_grant_after_rst", int'(wr_grant_id), 0);

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  $urandom_range(0, 1), $urandom_range(0, 63),
                  $urandom_range(0, 1), $urandom_range(0, 63),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
        end

        @(negedge clk);
        #3;
        chk("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
